mult_div_ctrl: RTL and testbench

- Multicycle sequencer for MIPS mult/div instructions.
- Owns the HI/LO registers that feed the RegData mux.
- Accepts a one-cycle start request from the control unit, iterates one bit per cycle, and raises a done pulse when HI/LO are valid.
- The control unit stalls in a wait state on busy.

---
 rtl/mult_div_pkg.sv | 32 +++
 rtl/mult_div_step.sv | 69 ++++++
 rtl/mult_div_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module   : mult_div_pkg
// Purpose  : Shared state encodings, operation codes and sizing constants for
//            the mult/div sequencer and its single-iteration datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int ITER_COUNT = DEF_WIDTH;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] MULT = 3'd1;
   localparam logic [2:0] DIV  = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   // Bit 1 selects divide, bit 0 selects unsigned operands.
   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_step.sv
// ============================================================================
// Module   : mult_div_step
// Purpose  : One combinational iteration: signed Booth radix-2, unsigned
//            shift-add, or restoring division on operand magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = ITER_COUNT
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH:0]   acc_in,
   input  logic [WIDTH-1:0] bits_in,
   input  logic             qm1_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH:0]   acc_out,
   output logic [WIDTH-1:0] bits_out,
   output logic             qm1_out
);

   logic [WIDTH:0]   w_ext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;

   always_comb begin
      w_ext    = {operand[WIDTH-1], operand};
      w_sum    = acc_in;
      w_shift  = {acc_in[WIDTH-1:0], bits_in[WIDTH-1]};
      w_trial  = {1'b0, w_shift} - {2'b00, operand};
      acc_out  = acc_in;
      bits_out = bits_in;
      qm1_out  = qm1_in;
      case (mode)
         OP_MULT: begin
            // The extra accumulator bit keeps (-2^(W-1))^2 from overflowing.
            case ({bits_in[0], qm1_in})
               2'b01:   w_sum = acc_in + w_ext;
               2'b10:   w_sum = acc_in - w_ext;
               default: w_sum = acc_in;
            endcase
            acc_out  = {w_sum[WIDTH], w_sum[WIDTH:1]};
            bits_out = {w_sum[0], bits_in[WIDTH-1:1]};
            qm1_out  = bits_in[0];
         end
         OP_MULTU: begin
            w_sum    = bits_in[0] ? (acc_in + {1'b0, operand}) : acc_in;
            acc_out  = {1'b0, w_sum[WIDTH:1]};
            bits_out = {w_sum[0], bits_in[WIDTH-1:1]};
            qm1_out  = bits_in[0];
         end
         default: begin
            if (!w_trial[WIDTH+1]) begin
               acc_out = w_trial[WIDTH:0];
            end else begin
               acc_out = w_shift;
            end
            bits_out = {bits_in[WIDTH-2:0], ~w_trial[WIDTH+1]};
            qm1_out  = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mult_div_ctrl.sv
// ============================================================================
// Module   : mult_div_ctrl
// Purpose  : Multicycle MIPS mult/div sequencer owning the HI/LO registers.
//            Optional macro MULT_DIV_UNSIGNED_EN adds the unsigned_op input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_ctrl
   import mult_div_pkg::*;
#(
   parameter int WIDTH = ITER_COUNT,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
   input  logic             unsigned_op,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_bits;
   logic             r_qm1;
   logic [WIDTH-1:0] r_operand;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_fix_stage;
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   logic             w_unsigned;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH:0]   w_acc_nxt;
   logic [WIDTH-1:0] w_bits_nxt;
   logic             w_qm1_nxt;

`ifdef MULT_DIV_UNSIGNED_EN
   assign w_unsigned = unsigned_op;
`else
   assign w_unsigned = 1'b0;
`endif

   assign w_abs_a = (op_a[WIDTH-1] && !w_unsigned) ? -op_a : op_a;
   assign w_abs_b = (op_b[WIDTH-1] && !w_unsigned) ? -op_b : op_b;
   assign w_rem   = r_acc[WIDTH-1:0];

   mult_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .mode     (r_op),
      .acc_in   (r_acc),
      .bits_in  (r_bits),
      .qm1_in   (r_qm1),
      .operand  (r_operand),
      .acc_out  (w_acc_nxt),
      .bits_out (w_bits_nxt),
      .qm1_out  (w_qm1_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_op        <= OP_MULT;
         r_acc       <= '0;
         r_bits      <= '0;
         r_qm1       <= 1'b0;
         r_operand   <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_fix_stage <= 1'b0;
         r_res_hi    <= '0;
         r_res_lo    <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_mult) begin
                  r_op      <= w_unsigned ? OP_MULTU : OP_MULT;
                  r_acc     <= '0;
                  r_bits    <= op_b;
                  r_qm1     <= 1'b0;
                  r_operand <= op_a;
                  r_cnt     <= CNT_W'(WIDTH - 1);
                  r_busy    <= 1'b1;
                  r_state   <= MULT;
               end else if (start_div) begin
                  r_busy <= 1'b1;
                  if (op_b == '0) begin
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_op      <= w_unsigned ? OP_DIVU : OP_DIV;
                     r_acc     <= '0;
                     r_bits    <= w_abs_a;
                     r_qm1     <= 1'b0;
                     r_operand <= w_abs_b;
                     r_neg_q   <= !w_unsigned && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                     r_neg_r   <= !w_unsigned && op_a[WIDTH-1];
                     r_cnt     <= CNT_W'(WIDTH - 1);
                     r_state   <= DIV;
                  end
               end
            end
            MULT, DIV: begin
               r_acc  <= w_acc_nxt;
               r_bits <= w_bits_nxt;
               r_qm1  <= w_qm1_nxt;
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            FIX: begin
               // Sign correction is registered first so the negators stay
               // off the HI/LO write path.
               if (!r_fix_stage) begin
                  r_fix_stage <= 1'b1;
                  if (op_is_div(r_op)) begin
                     r_res_lo <= r_neg_q ? -r_bits : r_bits;
                     r_res_hi <= r_neg_r ? -w_rem : w_rem;
                  end else begin
                     r_res_lo <= r_bits;
                     r_res_hi <= w_rem;
                  end
               end else begin
                  r_fix_stage <= 1'b0;
                  r_hi        <= r_res_hi;
                  r_lo        <= r_res_lo;
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: begin
               r_fix_stage <= 1'b0;
               r_done      <= 1'b0;
               r_div_zero  <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
// ============================================================================
// Module   : tb_mult_div_ctrl
// Purpose  : Directed self-checking bench for mult_div_ctrl (32-bit build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_ctrl;

   logic        clk;
   logic        reset;
   logic        start_mult;
   logic        start_div;
`ifdef MULT_DIV_UNSIGNED_EN
   logic        unsigned_op;
`endif
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp  = 0;
   int n_fail = 0;

   mult_div_ctrl #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
      .unsigned_op(unsigned_op),
`endif
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one start, then waits (bounded) for done. lat is the number of
   // clock edges after the start edge at which done is first seen.
   task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output logic busy_ok, output logic hold_ok);
      logic [31:0] hi0, lo0;
      hi0 = hi;
      lo0 = lo;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      start_mult = m;
      start_div  = d;
      op_a = a;
      op_b = b;
      tick();
      start_mult = 1'b0;
      start_div  = 1'b0;
      lat = 0;
      while (!done && lat < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
         tick();
         lat++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
   endtask

   // After the done cycle the block must drop done and busy.
   task automatic check_release(input string tag);
      tick();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int          lat;
      logic        busy_ok, hold_ok;
      int          ndone, dk;
      logic [31:0] dhi, dlo;
      logic        saw_done;

      reset = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
      unsigned_op = 1'b0;
`endif
      op_a = '0;
      op_b = '0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dz",   {31'd0, div_zero}, 32'd0);
      check("rst_hi",   hi, 32'd0);
      check("rst_lo",   lo, 32'd0);
      reset = 1'b1;
      tick();

      // 3 * -4 = -12
      run_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, lat, busy_ok, hold_ok);
      check("mul1_latency", lat, 32'd34);
      check("mul1_busy",    {31'd0, busy_ok}, 32'd1);
      check("mul1_hold",    {31'd0, hold_ok}, 32'd1);
      check("mul1_hi",      hi, 32'hFFFF_FFFF);
      check("mul1_lo",      lo, 32'hFFFF_FFF4);
      check("mul1_dz",      {31'd0, div_zero}, 32'd0);
      check_release("mul1");

      // (-2^31)^2 = 2^62
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, busy_ok, hold_ok);
      check("mul2_latency", lat, 32'd34);
      check("mul2_hi",      hi, 32'h4000_0000);
      check("mul2_lo",      lo, 32'h0000_0000);
      check_release("mul2");

      // 7 / -2 = -3 rem 1
      run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, busy_ok, hold_ok);
      check("div1_latency", lat, 32'd34);
      check("div1_lo",      lo, 32'hFFFF_FFFD);
      check("div1_hi",      hi, 32'h0000_0001);
      check_release("div1");

      // -7 / 2 = -3 rem -1
      run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, busy_ok, hold_ok);
      check("div2_lo", lo, 32'hFFFF_FFFD);
      check("div2_hi", hi, 32'hFFFF_FFFF);
      check_release("div2");

      // Overflowing quotient wraps without an exception
      run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ok, hold_ok);
      check("div3_lo", lo, 32'h8000_0000);
      check("div3_hi", hi, 32'h0000_0000);
      check("div3_dz", {31'd0, div_zero}, 32'd0);
      check_release("div3");

      // 0x451 / 0x20 = 0x22 rem 0x11, preloading HI/LO for the /0 case
      run_op(1'b0, 1'b1, 32'h451, 32'h20, lat, busy_ok, hold_ok);
      check("pre_lo", lo, 32'h22);
      check("pre_hi", hi, 32'h11);
      check_release("pre");

      // Divide by zero: done is visible in the cycle right after the start cycle
      run_op(1'b0, 1'b1, 32'd5, 32'd0, lat, busy_ok, hold_ok);
      check("dz_latency", lat, 32'd0);
      check("dz_flag",    {31'd0, div_zero}, 32'd1);
      check("dz_busy",    {31'd0, busy_ok}, 32'd1);
      check("dz_hi",      hi, 32'h11);
      check("dz_lo",      lo, 32'h22);
      check_release("dz");
      check("dz_flag_clear", {31'd0, div_zero}, 32'd0);

      // A start while busy is ignored; exactly one done with the first result
      start_mult = 1'b1;
      op_a = 32'd5;
      op_b = 32'd7;
      tick();
      start_mult = 1'b0;
      ndone = 0;
      dk = -1;
      dhi = '0;
      dlo = '0;
      for (int k = 0; k <= 45; k++) begin
         if (done) begin
            ndone++;
            dk  = k;
            dhi = hi;
            dlo = lo;
         end
         start_mult = (k == 10);
         op_a = (k == 10) ? 32'd9 : 32'd5;
         op_b = (k == 10) ? 32'd9 : 32'd7;
         tick();
      end
      start_mult = 1'b0;
      check("ign_ndone", ndone, 32'd1);
      check("ign_cycle", dk, 32'd34);
      check("ign_lo",    dlo, 32'd35);
      check("ign_hi",    dhi, 32'd0);

      // Reset 20 cycles into a multiply aborts it silently
      start_mult = 1'b1;
      op_a = 32'd6;
      op_b = 32'd7;
      tick();
      start_mult = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi",   hi, 32'd0);
      check("abort_lo",   lo, 32'd0);
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) saw_done = 1'b1;
         tick();
      end
      check("abort_quiet", {31'd0, saw_done}, 32'd0);

      // Both starts together: multiply wins (6*3, not 6/3)
      run_op(1'b1, 1'b1, 32'd6, 32'd3, lat, busy_ok, hold_ok);
      check("both_latency", lat, 32'd34);
      check("both_hi",      hi, 32'd0);
      check("both_lo",      lo, 32'd18);
      check_release("both");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
